// File: rtl/cos_round_pkg.sv
// Shared constants for the cosine rounding sweep: fp_round mode encodings and
// the sweep controller state encoding.
package cos_round_pkg;

  localparam logic [1:0] RND_DOWN   = 2'b00;
  localparam logic [1:0] RND_HALFUP = 2'b01;
  localparam logic [1:0] RND_EVEN   = 2'b10;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_FETCH = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_ROUND = 3'd3;
  localparam logic [2:0] ST_EMIT  = 3'd4;
  localparam logic [2:0] ST_DONE  = 3'd5;

endpackage

// File: rtl/cos_round_sweep_ctrl_mode_sel.sv
// Mode walker for the sweep: lowest enabled mode, the next enabled mode above
// the current one, and whether the current mode is the highest enabled.
module round_mode_sel
  import cos_round_pkg::*;
(
  input  logic [2:0] mask,
  input  logic [1:0] mode,
  output logic [1:0] lowest_mode,
  output logic [1:0] next_mode,
  output logic       is_highest
);

  always_comb begin
    lowest_mode = RND_EVEN;
    if (mask[0])      lowest_mode = RND_DOWN;
    else if (mask[1]) lowest_mode = RND_HALFUP;
  end

  always_comb begin
    next_mode  = mode;
    is_highest = 1'b1;
    case (mode)
      RND_DOWN: begin
        if (mask[1]) begin
          next_mode  = RND_HALFUP;
          is_highest = 1'b0;
        end else if (mask[2]) begin
          next_mode  = RND_EVEN;
          is_highest = 1'b0;
        end
      end
      RND_HALFUP: begin
        if (mask[2]) begin
          next_mode  = RND_EVEN;
          is_highest = 1'b0;
        end
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/cos_round_sweep_ctrl.sv
// Cycle-exact sweep of the PLA sample memory through fp_round, once per enabled
// rounding mode, onto a valid/ready stream. COS_SWEEP_STALL_CNT_EN adds stall_cnt.
module cos_round_sweep_ctrl
  import cos_round_pkg::*;
#(
  parameter int unsigned WI        = 2,
  parameter int unsigned WF        = 14,
  parameter int unsigned N_SAMPLES = 256,
  parameter int unsigned ADDR_W    = 8
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic                      start,
  input  logic [2:0]                mode_mask,
  output logic                      busy,
  output logic                      done,
  output logic                      mem_rd_en,
  output logic [ADDR_W-1:0]         mem_addr,
  input  logic [2*(WI+WF)-1:0]      mem_rdata,
  output logic [2*(WI+WF)-1:0]      rnd_in,
  output logic [1:0]                rnd_type,
  input  logic [WI+WF-1:0]          rnd_out,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [WI+WF-1:0]          out_data,
  output logic [ADDR_W-1:0]         out_idx,
  output logic [1:0]                out_type,
  output logic                      out_last
`ifdef COS_SWEEP_STALL_CNT_EN
  ,
  output logic [15:0]               stall_cnt
`endif
);

  localparam int unsigned RW = WI + WF;
  localparam int unsigned SW = 2 * RW;
  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(N_SAMPLES - 1);

  logic [2:0]        state, state_d;
  logic [2:0]        mask_q, mask_d, sel_mask;
  logic [1:0]        mode, mode_d;
  logic [1:0]        lowest_mode, next_mode;
  logic              is_highest, accept;
  logic [ADDR_W-1:0] idx_d;
  logic [SW-1:0]     sample_d;
  logic [1:0]        rnd_type_d, type_d;
  logic [RW-1:0]     data_d;
  logic [ADDR_W-1:0] oidx_d;
  logic              busy_d, done_d, rd_en_d, valid_d, last_d;

  // In IDLE the mode walker looks at the incoming mask so the first mode is known at accept
  assign sel_mask = (state == ST_IDLE) ? mode_mask : mask_q;
  assign accept   = (state == ST_IDLE) && start && (mode_mask != 3'b000);

  round_mode_sel u_mode_sel (
    .mask        (sel_mask),
    .mode        (mode),
    .lowest_mode (lowest_mode),
    .next_mode   (next_mode),
    .is_highest  (is_highest)
  );

  // Next-state and next-output logic
  always_comb begin
    state_d    = state;
    mask_d     = mask_q;
    mode_d     = mode;
    idx_d      = mem_addr;
    busy_d     = busy;
    done_d     = 1'b0;
    rd_en_d    = 1'b0;
    sample_d   = rnd_in;
    rnd_type_d = rnd_type;
    valid_d    = out_valid;
    data_d     = out_data;
    oidx_d     = out_idx;
    type_d     = out_type;
    last_d     = out_last;
    case (state)
      ST_IDLE: begin
        if (accept) begin
          mask_d  = mode_mask;
          idx_d   = '0;
          mode_d  = lowest_mode;
          busy_d  = 1'b1;
          rd_en_d = 1'b1;
          state_d = ST_FETCH;
        end
      end
      ST_FETCH: state_d = ST_WAIT;
      ST_WAIT: begin
        sample_d   = mem_rdata;
        rnd_type_d = mode;
        state_d    = ST_ROUND;
      end
      ST_ROUND: begin
        valid_d = 1'b1;
        data_d  = rnd_out;
        oidx_d  = mem_addr;
        type_d  = mode;
        last_d  = (mem_addr == LAST_IDX) && is_highest;
        state_d = ST_EMIT;
      end
      ST_EMIT: begin
        if (out_ready) begin
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (!is_highest) begin
            mode_d     = next_mode;
            rnd_type_d = next_mode;
            state_d    = ST_ROUND;
          end else if (mem_addr == LAST_IDX) begin
            done_d  = 1'b1;
            state_d = ST_DONE;
          end else begin
            idx_d   = mem_addr + ADDR_W'(1);
            mode_d  = lowest_mode;
            rd_en_d = 1'b1;
            state_d = ST_FETCH;
          end
        end
      end
      ST_DONE: begin
        busy_d  = 1'b0;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // mem_addr doubles as the sweep index; rnd_in doubles as the sample register
  always_ff @(posedge CLK) begin
    if (RST) begin
      state     <= ST_IDLE;
      mask_q    <= '0;
      mode      <= RND_DOWN;
      mem_addr  <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_rd_en <= 1'b0;
      rnd_in    <= '0;
      rnd_type  <= RND_DOWN;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_idx   <= '0;
      out_type  <= RND_DOWN;
      out_last  <= 1'b0;
    end else begin
      state     <= state_d;
      mask_q    <= mask_d;
      mode      <= mode_d;
      mem_addr  <= idx_d;
      busy      <= busy_d;
      done      <= done_d;
      mem_rd_en <= rd_en_d;
      rnd_in    <= sample_d;
      rnd_type  <= rnd_type_d;
      out_valid <= valid_d;
      out_data  <= data_d;
      out_idx   <= oidx_d;
      out_type  <= type_d;
      out_last  <= last_d;
    end
  end

`ifdef COS_SWEEP_STALL_CNT_EN
  // Saturating count of back-pressured output cycles for the current sweep
  always_ff @(posedge CLK) begin
    if (RST || accept) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != 16'hFFFF)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: doc/cos_round_sweep_ctrl.md
# cos_round_sweep_ctrl

Sequencing controller for the cosine-approximation rounding stage. On `start`, it walks the 256-entry PLA sample memory and feeds each sample to the shared `fp_round` datapath once per enabled rounding mode (down, half-up, even). Each rounded result goes out on a valid/ready stream, tagged with sample index and mode. It replaces the open-loop, delay-timed sweep with a cycle-exact, back-pressurable hardware sequence.

## Interface
Parameters:
- `WI`, 2, integer bits of rounded result
- `WF`, 14, fraction bits of rounded result
- `N_SAMPLES`, 256, number of PLA samples swept
- `ADDR_W`, 8, sample address width; requires 2**ADDR_W >= N_SAMPLES

Ports:
- `CLK`  in  1  single clock, rising edge
- `RST`  in  1  synchronous, active-high reset
- `start`  in  1  begin sweep; sampled only in IDLE
- `mode_mask`  in  3  modes to run per sample: bit0 down, bit1 half-up, bit2 even; latched on accepted start
- `busy`  out  1  high from accepted start until DONE completes
- `done`  out  1  one-cycle pulse after the last output handshake
- `mem_rd_en`  out  1  sample memory read strobe
- `mem_addr`  out  ADDR_W  sample address
- `mem_rdata`  in  2*(WI+WF)  sample data, valid one cycle after `mem_rd_en`
- `rnd_in`  out  2*(WI+WF)  operand to external `fp_round`
- `rnd_type`  out  2  mode to `fp_round`
- `rnd_out`  in  WI+WF  combinational result from `fp_round`
- `out_valid`  out  1  result valid
- `out_ready`  in  1  consumer ready
- `out_data`  out  WI+WF  rounded result
- `out_idx`  out  ADDR_W  sample index of `out_data`
- `out_type`  out  2  mode of `out_data`
- `out_last`  out  1  final output of the sweep

## Operation
- FSM states: IDLE, FETCH, WAIT, ROUND, EMIT, DONE.
- IDLE
  - If `start` is high and `mode_mask` != 0: latch the mask, clear the index, set the mode to the lowest set mask bit, go to FETCH.
  - If `start` is high and `mode_mask` == 0: ignore it and stay in IDLE.
- FETCH: `mem_rd_en`=1 with `mem_addr`=index. Next state WAIT.
- WAIT: register `mem_rdata` into the sample register. Next state ROUND.
- ROUND
  - Drive `rnd_in` from the sample register and `rnd_type` from the current mode.
  - Register `rnd_out`, the index, the mode and the last flag into the output registers. Next state EMIT.
- EMIT
  - `out_valid`=1; all `out_*` stay stable until `out_valid && out_ready`.
  - On handshake, if a higher mask bit is set: advance the mode to the next set bit and go to ROUND.
  - Otherwise, if index == N_SAMPLES-1: go to DONE.
  - Otherwise: increment the index, reload the mode to the lowest set bit and go to FETCH.
- DONE: `done`=1 for one cycle, then IDLE.
- `out_last`=1 only when index == N_SAMPLES-1 and the mode is the highest set bit of the mask.
- Mode encodings: down=00, half-up=01, even=10. Encoding 11 is never driven.
- `rnd_in`/`rnd_type` hold their last value outside ROUND.
- `start` while busy is ignored. `mode_mask` changes while busy have no effect.
- `RST` at any cycle, including mid-sweep, returns to IDLE; no further outputs are issued and no `done` pulse.
- Reset values: `busy`, `done`, `mem_rd_en`, `out_valid`, `out_last` = 0; `mem_addr`, `rnd_in`, `rnd_type`, `out_data`, `out_idx`, `out_type` = 0.

## Timing
- The `busy` register is set in the cycle after start is accepted.
- Per sample with `out_ready` held high:
  - First enabled mode: 4 cycles (FETCH, WAIT, ROUND, EMIT).
  - Each additional mode: 2 cycles (ROUND, EMIT).
- Full mask, no back-pressure: 8 cycles per sample, so 2048 cycles from FETCH of index 0 to the final handshake. `done` is asserted the next cycle.
- Each cycle of `out_ready`=0 in EMIT adds exactly one cycle.
- The memory read is fixed at one-cycle latency; there is no memory-side handshake.

## Configuration
- `COS_SWEEP_STALL_CNT_EN`
  - Defined: adds output `stall_cnt` [15:0], a saturating (at 16'hFFFF) count of cycles with `out_valid && !out_ready`. It clears on `RST` and on accepted start.
  - Undefined: the port and its logic are absent; behaviour is otherwise identical.

## Structure
- Shared package `cos_round_pkg`:
  - Rounding mode constants `RND_DOWN`=2'b00, `RND_HALFUP`=2'b01, `RND_EVEN`=2'b10.
  - The FSM state encoding.
- Sub-module `round_mode_sel`, combinational. Given the mask and the current mode, it returns the lowest set mode, the next set mode and an is-highest flag. It is used by EMIT and for `out_last`.
- `fp_round` stays external to this block.

## Test plan
- Bench stub: memory returns data = address; stub `fp_round` returns `rnd_in[WI+WF-1:0] + rnd_type`.
- Mask 3'b111, ready high:
  - 768 outputs, with `out_idx`/`out_type` sequence (0,00),(0,01),(0,10),(1,00)…
  - Sample 5 even yields `out_data`=7.
  - `out_last` only on (255,10); `done` one cycle after; 2048 cycles FETCH-to-last handshake.
- Mask 3'b100:
  - 256 outputs, all `out_type`=10; 4 cycles per sample; `rnd_type` never 00/01.
- Mask 3'b000 with start high for 3 cycles:
  - `busy`, `mem_rd_en`, `out_valid` stay 0; no `done`.
- Back-pressure:
  - `out_ready` low 5 cycles at sample 10 half-up; `out_*` stable throughout.
  - Sweep ends 5 cycles later; `stall_cnt`=5 when the macro is defined.
- Reset mid-sweep:
  - `RST` pulse during EMIT of sample 100 gives all outputs 0 next cycle and no `done`.
  - A new start restarts at index 0.
- Start while busy:
  - A second `start` at sample 50 with mask 3'b001 is ignored; the sweep continues with the original mask.
